// File: rtl/axil_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axil_pkg: AXI4-Lite response codes, prot default and arbiter FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_RESP = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching upward from ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int  cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axilite_master_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axilite_master_arb: round-robin sharing of one AXI4-Lite master, one txn in flight
// Rev 1.0
// ----------------------------------------------------------------------------
module axilite_master_arb
  import axil_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = 4,
  parameter  int DATA_W  = 32,
  localparam int STRB_W  = DATA_W / 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [ADDR_W-1:0]           m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_W-1:0]           m_axi_wdata,
  output logic [STRB_W-1:0]           m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [ADDR_W-1:0]           m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_W-1:0]           m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  state_t              state_q,   state_d;
  logic [IDX_W-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q,  w_done_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic [1:0]          resp_q,    resp_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                aw_fin;
  logic                w_fin;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A channel counts as done once its own handshake has happened, in this or an earlier cycle.
  assign aw_fin = aw_done_q | (m_axi_awvalid & m_axi_awready);
  assign w_fin  = w_done_q  | (m_axi_wvalid  & m_axi_wready);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          rr_ptr_d  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          idx_d     = arb_idx;
          addr_d    = req_addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[arb_idx*DATA_W +: DATA_W];
          wstrb_d   = req_wstrb[arb_idx*STRB_W +: STRB_W];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write[arb_idx] ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (m_axi_arready) begin
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      ST_IDLE:    req_ready = arb_gnt;
      ST_WR_REQ: begin
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = ~w_done_q;
      end
      ST_WR_RESP: m_axi_bready  = 1'b1;
      ST_RD_REQ:  m_axi_arvalid = 1'b1;
      ST_RD_RESP: m_axi_rready  = 1'b1;
      ST_DONE:    rsp_valid[idx_q] = 1'b1;
      default:    req_ready = '0;
    endcase
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

endmodule
`default_nettype wire
